seg7_scan_mux: RTL and testbench



---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_scan_mux_if.sv | 24 ++
 rtl/seg7_hex_decode.sv | 16 +
 rtl/seg7_scan_mux.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment display blocks.
//   SEG_OFF    : all segments dark (active-low pattern {g,f,e,d,c,b,a}).
//   HEX_SEG    : 16-entry hex-to-segment table, active low, index = nibble.
//   idx_width(): width of a digit index for a given digit count.
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; lower-case glyphs used for b and d so they
    // are distinguishable from 8 and 0.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Digit index width; at least one bit so a 1-digit build still elaborates.
    function automatic int idx_width(input int n_digits);
        return (n_digits <= 2) ? 1 : $clog2(n_digits);
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux_if
// Display-data bus between the display data registers and the scan mux.
//   digits : 4*N_DIGITS  hex nibble per digit, digit 0 in bits [3:0]
//   dp     : N_DIGITS    decimal point request per digit, active high
//   blank  : N_DIGITS    force digit dark, active high
//   bright : 4           brightness level 0..15
// Modports: master = register side (drives), slave = scan mux (samples).
//
// Handshake: there is no valid/ready pair. The bus is level-based; the slave
// samples every field on every clock and a change is visible on the very
// next output edge, so the master may update any field at any time.
// ----------------------------------------------------------------------------
interface seg7_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [3:0]            bright;

    modport master (output digits, dp, blank, bright);
    modport slave  (input  digits, dp, blank, bright);
endinterface

// File: rtl/seg7_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to seven-segment pattern.
//   hex : in  4  nibble 0..F
//   seg : out 7  active-low {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_mux.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed driver for N_DIGITS common-anode seven-segment digits with
// an anti-ghosting gap at the start of each slot and 16-level PWM brightness.
//
// Parameters:
//   N_DIGITS   : digits scanned (>= 2)
//   DIV_BITS   : slot length is 2^DIV_BITS clocks
//   GAP_CYCLES : anode-off clocks at the start of each slot,
//                must be < 2^(DIV_BITS-4)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   disp       : seg7_scan_mux_if.slave (digits, dp, blank, bright)
//   an         : anode enables, active low, at most one low
//   ca         : segments {g,f,e,d,c,b,a}, active low
//   dp_n       : decimal point segment, active low
//
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero
// digits (digit 0 is always shown).
//
// Timing: outputs are registered from the current (idx, cnt), so an, ca and
// dp_n all move on the same edge, one clock after the state they reflect.
// ----------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int DIV_BITS   = 17,
    parameter int GAP_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_mux_if.slave      disp,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          ca,
    output logic                dp_n
);

    localparam int IDX_W = idx_width(N_DIGITS);

    logic [DIV_BITS-1:0] cnt;
    logic [IDX_W-1:0]    idx;

    logic                in_gap;
    logic                in_on;
    logic [N_DIGITS-1:0] supp;
    logic [N_DIGITS-1:0] eff_blank;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [6:0]          cur_seg;
    logic [N_DIGITS-1:0] an_next;

    // ------------------------------------------------------------------
    // Slot counter and digit index. idx steps when cnt is about to wrap,
    // with an explicit wrap so non-power-of-two digit counts work.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase within the slot: the top nibble of cnt is the PWM level, so
    // brightness b keeps the anode on for (b+1)/16 of the slot, less the gap.
    // ------------------------------------------------------------------
    assign in_gap = (cnt < DIV_BITS'(GAP_CYCLES));
    assign in_on  = !in_gap && (cnt[DIV_BITS-1 -: 4] <= disp.bright);

    // ------------------------------------------------------------------
    // Leading-zero suppression: walk from the top digit down while every
    // nibble seen so far is zero. Digit 0 is never part of the walk.
    // ------------------------------------------------------------------
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic all_zero;

    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (disp.digits[4*i +: 4] == 4'h0);
            supp[i]  = all_zero;
        end
    end
`else
    assign supp = '0;
`endif

    assign eff_blank = disp.blank | supp;

    // ------------------------------------------------------------------
    // Select the current digit's data (explicit compare mux so idx codes
    // beyond N_DIGITS-1 never index out of range).
    // ------------------------------------------------------------------
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp.digits[4*i +: 4];
                cur_dp    = disp.dp[i];
                cur_blank = eff_blank[i];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .hex (cur_nib),
        .seg (cur_seg)
    );

    always_comb begin
        an_next = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (in_on && !cur_blank && (idx == IDX_W'(i))) begin
                an_next[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers. ca/dp_n follow idx through GAP and DARK so the
    // segment lines are already settled when the anode turns on.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= '1;
            ca   <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_next;
            ca   <= cur_blank ? SEG_OFF : cur_seg;
            dp_n <= cur_blank | ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int DIV_BITS = 8;
    localparam int GAP      = 4;
    localparam int SLOT     = 256;

    // Reference glyphs, active low {g..a}, indexed by nibble.
    localparam logic [6:0] REF_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an4;
    logic [6:0] ca4;
    logic       dpn4;
    logic [5:0] an6;
    logic [6:0] ca6;
    logic       dpn6;

    int k;        // active clock edges since the last reset release
    int n_vec;
    int n_err;

    seg7_scan_mux_if #(.N_DIGITS(4)) bus4 ();
    seg7_scan_mux_if #(.N_DIGITS(6)) bus6 ();

    seg7_scan_mux #(.N_DIGITS(4), .DIV_BITS(DIV_BITS), .GAP_CYCLES(GAP)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (bus4),
        .an    (an4),
        .ca    (ca4),
        .dp_n  (dpn4)
    );

    seg7_scan_mux #(.N_DIGITS(6), .DIV_BITS(DIV_BITS), .GAP_CYCLES(GAP)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (bus6),
        .an    (an6),
        .ca    (ca6),
        .dp_n  (dpn6)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // ---------------- reference model ----------------
    // Output after active edge kk (kk >= 1) shows time step kk-1 of the scan:
    // slot = (kk-1)/SLOT picks the digit, position inside the slot picks phase.
    // Returns {an[5:0], ca[6:0], dp_n}.
    function automatic logic [13:0] model(input int n, input int kk,
                                          input logic [23:0] dg,
                                          input logic [5:0] dpm,
                                          input logic [5:0] bl,
                                          input logic [3:0] br);
        int         pos;
        int         d;
        logic [3:0] nib;
        logic       eff;
        logic       on;
        logic [5:0] a;
        logic [6:0] c;
        logic       p;
        logic [23:0] upper;
        pos   = (kk - 1) % SLOT;
        d     = ((kk - 1) / SLOT) % n;
        upper = dg >> (4 * d);
        nib   = upper[3:0];
        eff   = bl[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d >= 1 && upper == 24'h0) eff = 1'b1;
`endif
        on = (pos >= GAP) && ((pos / 16) <= int'(br));
        a  = 6'h3F;
        if (on && !eff) a[d] = 1'b0;
        c = eff ? 7'h7F : REF_SEG[nib];
        p = eff ? 1'b1 : ~dpm[d];
        return {a, c, p};
    endfunction

    task automatic randomize_inputs();
        bus4.digits = 16'($urandom);
        bus4.dp     = 4'($urandom);
        bus4.blank  = 4'($urandom_range(0, 15) < 4 ? $urandom : 0);
        bus4.bright = 4'($urandom_range(0, 15));
        bus6.digits = 24'($urandom);
        bus6.dp     = 6'($urandom);
        bus6.blank  = 6'($urandom_range(0, 15) < 4 ? $urandom : 0);
        bus6.bright = 4'($urandom_range(0, 15));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first;
        randomize_inputs();
        bus4.digits = 16'h1234;
        bus4.blank  = 4'h0;
        bus4.bright = 4'hF;
        bus6.blank  = 6'h0;
        bus6.bright = 4'hF;
        while ((k - 1) % SLOT != 128 || k < SLOT) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({an4, ca4, dpn4} !== {4'hF, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL reset_async4 got an=%b ca=%b dp_n=%b exp 1111/1111111/1", an4, ca4, dpn4);
        end
        n_vec++;
        if ({an6, ca6, dpn6} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL reset_async6 got an=%b ca=%b dp_n=%b exp 111111/1111111/1", an6, ca6, dpn6);
        end
        tick();
        tick();
        n_vec++;
        if ({an4, ca4, dpn4} !== {4'hF, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL reset_hold got an=%b ca=%b dp_n=%b exp 1111/1111111/1", an4, ca4, dpn4);
        end
        rst_n = 1'b1;
        k     = 0;
        first = -1;
        while (first < 0 && k < 40) begin
            tick();
            if (an4 !== 4'hF) first = k;
        end
        n_vec++;
        if (first != GAP + 1 || an4 !== 4'b1110) begin
            n_err++;
            $display("FAIL reset_first_anode got edge=%0d an=%b exp edge=%0d an=1110", first, an4, GAP + 1);
        end
    endtask

    task automatic test_scan_order();
        logic [13:0] e;
        logic [3:0]  exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0]  exp_ca  [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        logic        exp_dpn [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bus4.digits = 16'h12AF;
        bus4.dp     = 4'b0100;
        bus4.blank  = 4'h0;
        bus4.bright = 4'hF;
        while (k % (4 * SLOT) != 0) tick();
        for (int s = 0; s < 5; s++) begin
            for (int p = 0; p < SLOT; p++) begin
                tick();
                e = model(4, k, {8'h0, bus4.digits}, {2'b0, bus4.dp}, {2'b0, bus4.blank}, bus4.bright);
                n_vec++;
                if ({an4, ca4, dpn4} !== {e[11:8], e[7:0]}) begin
                    n_err++;
                    $display("FAIL scan_model k=%0d got %b/%b/%b exp %b/%b/%b",
                             k, an4, ca4, dpn4, e[11:8], e[7:1], e[0]);
                end
                if (p == 128) begin
                    n_vec++;
                    if ({an4, ca4, dpn4} !== {exp_an[s%4], exp_ca[s%4], exp_dpn[s%4]}) begin
                        n_err++;
                        $display("FAIL scan_order slot=%0d got %b/%b/%b exp %b/%b/%b",
                                 s, an4, ca4, dpn4, exp_an[s%4], exp_ca[s%4], exp_dpn[s%4]);
                    end
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [3:0] levels [3] = '{4'd0, 4'd7, 4'd15};
        int         exp_lit [3] = '{12, 124, 252};
        int         lit;
        int         gap_bad;
        bus4.blank  = 4'h0;
        bus4.digits = 16'h8888;
        for (int i = 0; i < 3; i++) begin
            bus4.bright = levels[i];
            while (k % SLOT != 0) tick();
            lit     = 0;
            gap_bad = 0;
            for (int p = 0; p < SLOT; p++) begin
                tick();
                if (an4 !== 4'hF) lit++;
                if (p < GAP && an4 !== 4'hF) gap_bad++;
            end
            n_vec++;
            if (lit != exp_lit[i]) begin
                n_err++;
                $display("FAIL pwm_on_clocks bright=%0d got %0d exp %0d", levels[i], lit, exp_lit[i]);
            end
            n_vec++;
            if (gap_bad != 0) begin
                n_err++;
                $display("FAIL pwm_gap bright=%0d got %0d lit gap clocks exp 0", levels[i], gap_bad);
            end
        end
    endtask

    task automatic test_blank();
        logic [13:0] e;
        bus4.digits = 16'($urandom);
        bus4.dp     = 4'hF;
        bus4.blank  = 4'b0010;
        bus4.bright = 4'hF;
        while (k % (4 * SLOT) != 0) tick();
        for (int p = 0; p < 4 * SLOT; p++) begin
            tick();
            e = model(4, k, {8'h0, bus4.digits}, {2'b0, bus4.dp}, {2'b0, bus4.blank}, bus4.bright);
            n_vec++;
            if ({an4, ca4, dpn4} !== {e[11:8], e[7:0]}) begin
                n_err++;
                $display("FAIL blank_model k=%0d got %b/%b/%b exp %b/%b/%b",
                         k, an4, ca4, dpn4, e[11:8], e[7:1], e[0]);
            end
            if (p / SLOT == 1) begin
                n_vec++;
                if ({an4, ca4, dpn4} !== {4'hF, 7'h7F, 1'b1}) begin
                    n_err++;
                    $display("FAIL blank_digit1 k=%0d got %b/%b/%b exp 1111/1111111/1", k, an4, ca4, dpn4);
                end
            end
        end
    endtask

    task automatic test_six_digits();
        logic [13:0] e;
        bus6.digits = 24'($urandom);
        bus6.dp     = 6'($urandom);
        bus6.blank  = 6'h0;
        bus6.bright = 4'hF;
        while (k % (6 * SLOT) != 0) tick();
        for (int p = 0; p < 7 * SLOT; p++) begin
            tick();
            e = model(6, k, bus6.digits, bus6.dp, bus6.blank, bus6.bright);
            n_vec++;
            if ({an6, ca6, dpn6} !== e) begin
                n_err++;
                $display("FAIL six_model k=%0d got %b/%b/%b exp %b/%b/%b",
                         k, an6, ca6, dpn6, e[13:8], e[7:1], e[0]);
            end
            n_vec++;
            if ($countones(~an6) > 1) begin
                n_err++;
                $display("FAIL six_onehot k=%0d got an=%b exp at most one low", k, an6);
            end
            if (p == 5 * SLOT + 128) begin
                n_vec++;
                if (an6 !== 6'b011111) begin
                    n_err++;
                    $display("FAIL six_last_digit got an=%b exp 011111", an6);
                end
            end
            if (p == 6 * SLOT + 128) begin
                n_vec++;
                if (an6 !== 6'b111110) begin
                    n_err++;
                    $display("FAIL six_wrap got an=%b exp 111110", an6);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [13:0] e;
        logic [15:0] pats [2] = '{16'h0050, 16'h0000};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic [3:0] exp_an [2][4] = '{'{4'b1110, 4'b1101, 4'hF, 4'hF},
                                     '{4'b1110, 4'hF, 4'hF, 4'hF}};
`else
        logic [3:0] exp_an [2][4] = '{'{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                                     '{4'b1110, 4'b1101, 4'b1011, 4'b0111}};
`endif
        bus4.dp     = 4'hF;
        bus4.blank  = 4'h0;
        bus4.bright = 4'hF;
        for (int t = 0; t < 2; t++) begin
            bus4.digits = pats[t];
            while (k % (4 * SLOT) != 0) tick();
            for (int p = 0; p < 4 * SLOT; p++) begin
                tick();
                e = model(4, k, {8'h0, bus4.digits}, {2'b0, bus4.dp}, {2'b0, bus4.blank}, bus4.bright);
                n_vec++;
                if ({an4, ca4, dpn4} !== {e[11:8], e[7:0]}) begin
                    n_err++;
                    $display("FAIL lz_model k=%0d got %b/%b/%b exp %b/%b/%b",
                             k, an4, ca4, dpn4, e[11:8], e[7:1], e[0]);
                end
                if (p % SLOT == 128) begin
                    n_vec++;
                    if (an4 !== exp_an[t][p/SLOT]) begin
                        n_err++;
                        $display("FAIL lz_anode digits=%h slot=%0d got %b exp %b",
                                 pats[t], p / SLOT, an4, exp_an[t][p/SLOT]);
                    end
                end
                if (p == 128) begin
                    n_vec++;
                    if (ca4 !== 7'b1000000) begin
                        n_err++;
                        $display("FAIL lz_digit0 digits=%h got ca=%b exp 1000000", pats[t], ca4);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] e;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) randomize_inputs();
            tick();
            e = model(4, k, {8'h0, bus4.digits}, {2'b0, bus4.dp}, {2'b0, bus4.blank}, bus4.bright);
            n_vec++;
            if ({an4, ca4, dpn4} !== {e[11:8], e[7:0]}) begin
                n_err++;
                $display("FAIL rand4 k=%0d got %b/%b/%b exp %b/%b/%b",
                         k, an4, ca4, dpn4, e[11:8], e[7:1], e[0]);
            end
            e = model(6, k, bus6.digits, bus6.dp, bus6.blank, bus6.bright);
            n_vec++;
            if ({an6, ca6, dpn6} !== e) begin
                n_err++;
                $display("FAIL rand6 k=%0d got %b/%b/%b exp %b/%b/%b",
                         k, an6, ca6, dpn6, e[13:8], e[7:1], e[0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        k     = 0;
        n_vec = 0;
        n_err = 0;
        randomize_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k     = 0;

        test_reset();
        test_scan_order();
        test_pwm();
        test_blank();
        test_six_digits();
        test_leading_zero();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL timeout k=%0d exp bench to finish within time limit", k);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
